// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder, generators (7,5) octal.
// One bit in per handshake, one registered pair out, optional zero tail.
module conv_encoder_k3 #(
    parameter bit FLUSH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic       s_bit,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_valid,
    output logic [1:0] m_pair,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        TAIL0 = 2'd1,
        TAIL1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] sr_q, sr_d;
    logic       valid_q, valid_d;
    logic [1:0] pair_q, pair_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       free;
    logic       take;

    function automatic logic [1:0] enc(input logic b, input logic [1:0] sr);
        return {b ^ sr[0] ^ sr[1], b ^ sr[1]};
    endfunction

    always_comb begin
        free    = !valid_q || m_ready;
        s_ready = !rst && (state_q == DATA) && free;
        take    = s_valid && s_ready;
        state_d = state_q;
        sr_d    = sr_q;
        valid_d = valid_q;
        pair_d  = pair_q;
        last_d  = last_q;
        busy_d  = busy_q;
        // a load below overrides the drop, so back-to-back frames keep busy
        if (valid_q && m_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (last_q) busy_d = 1'b0;
        end
        unique case (state_q)
            DATA: begin
                if (take) begin
                    valid_d = 1'b1;
                    pair_d  = enc(s_bit, sr_q);
                    last_d  = 1'b0;
                    busy_d  = 1'b1;
                    sr_d    = {sr_q[0], s_bit};
                    if (s_last) begin
                        if (FLUSH) begin
                            state_d = TAIL0;
                        end else begin
                            last_d = 1'b1;
                            sr_d   = 2'b00;
                        end
                    end
                end
            end
            TAIL0: begin
                if (free) begin
                    valid_d = 1'b1;
                    pair_d  = enc(1'b0, sr_q);
                    last_d  = 1'b0;
                    sr_d    = {sr_q[0], 1'b0};
                    state_d = TAIL1;
                end
            end
            TAIL1: begin
                if (free) begin
                    valid_d = 1'b1;
                    pair_d  = enc(1'b0, sr_q);
                    last_d  = 1'b1;
                    sr_d    = 2'b00;
                    state_d = DATA;
                end
            end
            default: state_d = DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DATA;
            sr_q    <= 2'b00;
            valid_q <= 1'b0;
            pair_q  <= 2'b00;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            valid_q <= valid_d;
            pair_q  <= pair_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign m_valid = valid_q;
    assign m_pair  = pair_q;
    assign m_last  = last_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: directed frames plus a random stalled frame
// scored against a per-frame (7,5) convolution model.
module tb_conv_encoder_k3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0, s_bit = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic       s_ready, m_valid, m_last, busy;
    logic [1:0] m_pair;

    logic       f_s_valid = 1'b0, f_s_bit = 1'b0, f_s_last = 1'b0;
    logic       f_m_ready = 1'b1;
    logic       f_s_ready, f_m_valid, f_m_last, f_busy;
    logic [1:0] f_m_pair;

    int         n_cmp = 0;
    int         n_err = 0;
    int         acc_cnt = 0;
    logic [2:0] expq[$];
    bit         fb[$];
    bit         stall_prev = 1'b0;
    logic [1:0] prev_pair;
    logic       prev_last;
    logic [2:0] e;

    conv_encoder_k3 #(.FLUSH(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_bit(s_bit), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_pair(m_pair), .m_last(m_last),
        .m_ready(m_ready), .busy(busy)
    );

    conv_encoder_k3 #(.FLUSH(1'b0)) u_noflush (
        .clk(clk), .rst(rst),
        .s_valid(f_s_valid), .s_bit(f_s_bit), .s_last(f_s_last),
        .s_ready(f_s_ready),
        .m_valid(f_m_valid), .m_pair(f_m_pair), .m_last(f_m_last),
        .m_ready(f_m_ready), .busy(f_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pair for the newest bit of the frame: convolution over the frame history
    function automatic logic [1:0] conv_newest();
        int n;
        bit x0, x1, x2;
        n  = fb.size();
        x0 = fb[n-1];
        x1 = (n >= 2) ? fb[n-2] : 1'b0;
        x2 = (n >= 3) ? fb[n-3] : 1'b0;
        return {x0 ^ x1 ^ x2, x0 ^ x2};
    endfunction

    task automatic model_push(input bit b, input bit last);
        fb.push_back(b);
        expq.push_back({conv_newest(), 1'b0});
        if (last) begin
            fb.push_back(1'b0);
            expq.push_back({conv_newest(), 1'b0});
            fb.push_back(1'b0);
            expq.push_back({conv_newest(), 1'b1});
            fb.delete();
        end
    endtask

    // sample at negedge, then advance to just after the next posedge
    task automatic step();
        @(negedge clk);
        if (stall_prev)
            chk("stall_hold", {5'd0, m_valid, m_pair, m_last},
                {5'd0, 1'b1, prev_pair, prev_last});
        if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
                chk("extra_pair", {5'd0, m_pair, m_last}, 8'hff);
            end else begin
                e = expq.pop_front();
                chk("pair", {5'd0, m_pair, m_last}, {5'd0, e});
            end
        end
        if (s_valid && s_ready) begin
            model_push(s_bit, s_last);
            acc_cnt++;
        end
        stall_prev = m_valid && !m_ready;
        prev_pair  = m_pair;
        prev_last  = m_last;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int c = 0; c < 200 && expq.size() != 0; c++) step();
        chk(tag, expq.size(), 8'd0);
    endtask

    initial begin
        #1;
        chk("rst_sready", {7'd0, s_ready}, 8'd0);
        #20;
        chk("rst_outs", {4'd0, m_valid, m_pair, m_last}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("sready_after_rst", {7'd0, s_ready}, 8'd1);

        // no-flush instance: 1,1(last) then 1
        f_s_valid = 1'b1; f_s_bit = 1'b1; f_s_last = 1'b0;
        @(posedge clk); #1;
        chk("nf_p0", {5'd0, f_m_pair, f_m_last}, {5'd0, 2'b11, 1'b0});
        f_s_last = 1'b1;
        @(posedge clk); #1;
        chk("nf_p1", {5'd0, f_m_pair, f_m_last}, {5'd0, 2'b01, 1'b1});
        chk("nf_sready", {7'd0, f_s_ready}, 8'd1);
        f_s_last = 1'b0;
        @(posedge clk); #1;
        chk("nf_p2", {5'd0, f_m_pair, f_m_last}, {5'd0, 2'b11, 1'b0});
        f_s_valid = 1'b0;
        @(posedge clk); #1;
        chk("nf_idle", {6'd0, f_m_valid, f_busy}, 8'd1);

        // frame 1,0,1,1 with flush
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_bit   = (i != 1);
            s_last  = (i == 3);
            step();
            if (i == 0)
                chk("latency", {5'd0, m_valid, m_pair}, {5'd0, 3'b111});
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("tail_sready0", {7'd0, s_ready}, 8'd0);
        step();
        chk("tail_sready1", {7'd0, s_ready}, 8'd0);
        chk("tail_busy", {7'd0, busy}, 8'd1);
        step();
        chk("tail_sready2", {7'd0, s_ready}, 8'd1);
        chk("last_pair", {5'd0, m_pair, m_last}, {5'd0, 2'b11, 1'b1});
        drain("drain1");
        step();
        chk("busy_idle", {6'd0, m_valid, busy}, 8'd0);

        // two single-bit frames back to back
        acc_cnt = 0;
        s_valid = 1'b1; s_bit = 1'b1; s_last = 1'b1;
        for (int c = 0; c < 20 && acc_cnt < 2; c++) step();
        chk("b2b_acc", acc_cnt[7:0], 8'd2);
        drain("drain2");

        // random 64-bit frame under random backpressure
        acc_cnt = 0;
        for (int c = 0; c < 2000 && acc_cnt < 64; c++) begin
            s_valid = 1'b1;
            s_bit   = 1'($urandom);
            s_last  = (acc_cnt == 63);
            m_ready = 1'($urandom);
            step();
        end
        chk("rnd_acc", acc_cnt[7:0], 8'd64);
        s_valid = 1'b0; s_last = 1'b0;
        for (int c = 0; c < 400 && expq.size() != 0; c++) begin
            m_ready = 1'($urandom);
            step();
        end
        m_ready = 1'b1;
        drain("drain_rnd");
        step();

        // async reset while stalled in the tail
        m_ready = 1'b0;
        s_valid = 1'b1; s_bit = 1'b1; s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        step();
        chk("pre_rst_busy", {6'd0, m_valid, busy}, 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_outs", {5'd0, m_valid, busy, s_ready}, 8'd0);
        expq.delete();
        fb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_sready", {7'd0, s_ready}, 8'd1);
        m_ready = 1'b1;
        s_valid = 1'b1; s_bit = 1'b0; s_last = 1'b1;
        step();
        chk("post_rst_pair", {5'd0, m_valid, m_pair}, {5'd0, 3'b100});
        drain("drain_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
